// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage that sits in front of the IF/ID register.
//   It owns the fetch PC and issues in-order requests to instruction memory
//   over a req/gnt/rvalid handshake. Returned words are buffered in a DEPTH-entry
//   FIFO as {pc, inst} and presented one per cycle to decode. A redirect flushes
//   the FIFO, restarts fetch at the new PC and marks all in-flight requests stale.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   imem_req/addr (out)           request valid / byte address (= fetch PC)
//   imem_gnt (in)                 memory accepted the request this cycle
//   imem_rvalid/rdata (in)        in-order response valid / instruction word
//   redirect/redirect_pc (in)     taken branch/jump and its target
//   stall (in)                    decode cannot accept the head entry
//   if_valid/if_pc/if_inst (out)  head entry toward decode (NOP when empty)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam int          PW  = $clog2(DEPTH);
  localparam int          CW  = $clog2(DEPTH) + 1;  // holds 0..DEPTH
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, outst_q, discard_q;
  logic [31:0]     fpc_q, rpc_q;

  logic [CW-1:0]   outst_d;
  logic [CW:0]     credit_used;
  logic [31:0]     redir_pc_aligned;
  logic            grant, push, pop;

  // Credit counts both words already buffered and words still in flight, so
  // every granted request is guaranteed a FIFO slot. A pop in the same cycle
  // does not free credit, which keeps this path short.
  assign credit_used      = {1'b0, outst_q} + {1'b0, count_q};
  assign imem_req         = !rst && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr        = fpc_q;
  assign grant            = imem_req && imem_gnt;
  assign redir_pc_aligned = redirect_pc & 32'hFFFF_FFFC;

  // Responses are consumed either as stale (discard) or as new-stream data;
  // during a redirect the returning word belongs to the old stream.
  assign push = imem_rvalid && (discard_q == '0) && !redirect;
  assign pop  = if_valid && !stall && !redirect;

  assign outst_d = outst_q + CW'(grant) - CW'(imem_rvalid);

  // Outputs come only from registered FIFO state.
  assign if_valid = (count_q != '0);
  assign if_pc    = if_valid ? fifo_q[rd_ptr_q].pc   : 32'h0;
  assign if_inst  = if_valid ? fifo_q[rd_ptr_q].inst : NOP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q     <= RESET_PC;
      rpc_q     <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      outst_q <= outst_d;
      if (redirect) begin
        fpc_q     <= redir_pc_aligned;
        rpc_q     <= redir_pc_aligned;
        count_q   <= '0;
        rd_ptr_q  <= '0;
        wr_ptr_q  <= '0;
        // Everything still in flight after this cycle is stale; this already
        // covers drops pending from an earlier redirect.
        discard_q <= outst_d;
      end else begin
        if (grant) fpc_q <= fpc_q + 32'd4;
        if (imem_rvalid && (discard_q != '0)) discard_q <= discard_q - CW'(1);
        if (push) begin
          fifo_q[wr_ptr_q] <= '{pc: rpc_q, inst: imem_rdata};
          wr_ptr_q         <= wr_ptr_q + PW'(1);
          rpc_q            <= rpc_q + 32'd4;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

endmodule
